// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: opcodes, ALUOp codes and
// the control bundle carried through the pipeline registers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  // Field order matches the main decoder output, MSB first.
  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       extd;
    logic       jump;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: a load in EX whose destination is a source of
// the instruction currently in ID.
module load_use_detect
  import mips_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic                  id_jump,
  input  logic                  id_regdst,
  input  logic                  id_memwrite,
  input  logic                  id_branch,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_valid,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  hz
);

  logic uses_rs;
  logic uses_rt;

  always_comb begin
    uses_rs = id_valid & ~id_jump;
    uses_rt = id_valid & (id_regdst | id_memwrite | id_branch);
    // $0 is hardwired, so a load targeting it never creates a dependency.
    hz = ex_valid & ex_memread & (ex_rt != '0) &
         ((uses_rs & (ex_rt == id_rs)) | (uses_rt & (ex_rt == id_rt)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, downstream
// hold and a saturating count of inserted load-use bubbles.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_regdst,
  input  logic                  id_alusrc,
  input  logic                  id_memtoreg,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_memwrite,
  input  logic                  id_branch,
  input  logic                  id_extd,
  input  logic                  id_jump,
  input  logic [1:0]            id_aluop,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0]     id_rdata1,
  input  logic [DATA_W-1:0]     id_rdata2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [DATA_W-1:0]     id_pc4,
  input  logic                  flush,
  input  logic                  ex_hold,
  output logic                  ex_regdst,
  output logic                  ex_alusrc,
  output logic                  ex_memtoreg,
  output logic                  ex_regwrite,
  output logic                  ex_memread,
  output logic                  ex_memwrite,
  output logic                  ex_branch,
  output logic                  ex_extd,
  output logic                  ex_jump,
  output logic [1:0]            ex_aluop,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [DATA_W-1:0]     ex_rdata1,
  output logic [DATA_W-1:0]     ex_rdata2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [DATA_W-1:0]     ex_pc4,
  output logic                  ex_valid,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic [CNT_W-1:0]      stall_count
);

  ctrl_t                 id_ctrl;
  ctrl_t                 ctrl_q;
  logic                  valid_q;
  logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;
  logic [DATA_W-1:0]     rdata1_q, rdata2_q, imm_q, pc4_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  hz;

  always_comb begin
    id_ctrl = '{regdst:   id_regdst,
                alusrc:   id_alusrc,
                memtoreg: id_memtoreg,
                regwrite: id_regwrite,
                memread:  id_memread,
                memwrite: id_memwrite,
                branch:   id_branch,
                extd:     id_extd,
                jump:     id_jump,
                aluop:    id_aluop};
  end

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .id_valid    (id_valid),
    .id_jump     (id_jump),
    .id_regdst   (id_regdst),
    .id_memwrite (id_memwrite),
    .id_branch   (id_branch),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_valid    (valid_q),
    .ex_memread  (ctrl_q.memread),
    .ex_rt       (rt_q),
    .hz          (hz)
  );

  always_ff @(posedge clk) begin
    if (rst || flush || (!ex_hold && hz)) begin
      ctrl_q   <= CTRL_NOP;
      valid_q  <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      pc4_q    <= '0;
      if (rst) begin
        cnt_q <= '0;
      end else if (!flush && (cnt_q != '1)) begin
        // Only genuine load-use bubbles count; a flush bubble takes precedence.
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (!ex_hold) begin
      ctrl_q   <= id_valid ? id_ctrl : CTRL_NOP;
      valid_q  <= id_valid;
      rs_q     <= id_rs;
      rt_q     <= id_rt;
      rd_q     <= id_rd;
      rdata1_q <= id_rdata1;
      rdata2_q <= id_rdata2;
      imm_q    <= id_imm;
      pc4_q    <= id_pc4;
    end
  end

  // A flush must let the fetch redirect through even if ID would otherwise stall.
  assign pc_write   = rst | flush | ~(ex_hold | hz);
  assign ifid_write = pc_write;

  assign ex_regdst   = ctrl_q.regdst;
  assign ex_alusrc   = ctrl_q.alusrc;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_branch   = ctrl_q.branch;
  assign ex_extd     = ctrl_q.extd;
  assign ex_jump     = ctrl_q.jump;
  assign ex_aluop    = ctrl_q.aluop;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;
  assign ex_rdata1   = rdata1_q;
  assign ex_rdata2   = rdata2_q;
  assign ex_imm      = imm_q;
  assign ex_pc4      = pc4_q;
  assign ex_valid    = valid_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic, all
// checked against a slot-level reference model of the EX stage.
module tb_id_ex_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 2;
  localparam int          CNT_MAX = (1 << CW) - 1;

  // Control vectors, MSB first: regdst alusrc memtoreg regwrite memread
  // memwrite branch extd jump aluop[1:0]
  localparam bit [10:0] C_ADDI  = 11'b010_1000_0011;
  localparam bit [10:0] C_LW    = 11'b011_1100_0000;
  localparam bit [10:0] C_RTYPE = 11'b100_1000_0010;
  localparam bit [10:0] C_BEQ   = 11'b000_0001_0001;
  localparam bit [10:0] C_SW    = 11'b010_0010_0000;
  localparam bit [10:0] C_J     = 11'b000_0000_0100;

  logic clk = 1'b0;
  logic rst, id_valid, flush, ex_hold;
  logic [10:0] id_ctrl;
  logic id_regdst, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite;
  logic id_branch, id_extd, id_jump;
  logic [1:0] id_aluop;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rdata1, id_rdata2, id_imm, id_pc4;
  logic ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite;
  logic ex_branch, ex_extd, ex_jump;
  logic [1:0] ex_aluop;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic ex_valid, pc_write, ifid_write;
  logic [CW-1:0] stall_count;

  assign {id_regdst, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite,
          id_branch, id_extd, id_jump, id_aluop} = id_ctrl;

  always #5 clk = ~clk;

  id_ex_stage #(
    .DATA_W     (DW),
    .REG_ADDR_W (AW),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_regdst   (id_regdst),
    .id_alusrc   (id_alusrc),
    .id_memtoreg (id_memtoreg),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_memwrite (id_memwrite),
    .id_branch   (id_branch),
    .id_extd     (id_extd),
    .id_jump     (id_jump),
    .id_aluop    (id_aluop),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_rdata1   (id_rdata1),
    .id_rdata2   (id_rdata2),
    .id_imm      (id_imm),
    .id_pc4      (id_pc4),
    .flush       (flush),
    .ex_hold     (ex_hold),
    .ex_regdst   (ex_regdst),
    .ex_alusrc   (ex_alusrc),
    .ex_memtoreg (ex_memtoreg),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_memwrite (ex_memwrite),
    .ex_branch   (ex_branch),
    .ex_extd     (ex_extd),
    .ex_jump     (ex_jump),
    .ex_aluop    (ex_aluop),
    .ex_rs       (ex_rs),
    .ex_rt       (ex_rt),
    .ex_rd       (ex_rd),
    .ex_rdata1   (ex_rdata1),
    .ex_rdata2   (ex_rdata2),
    .ex_imm      (ex_imm),
    .ex_pc4      (ex_pc4),
    .ex_valid    (ex_valid),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .stall_count (stall_count)
  );

  typedef struct {
    bit        valid;
    bit [10:0] ctrl;
    bit [4:0]  rs, rt, rd;
    bit [31:0] d1, d2, imm, pc4;
  } slot_t;

  slot_t m;
  int    m_cnt;
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The instruction in EX is a load whose destination ID reads as a source.
  function automatic bit ref_hz();
    bit reads_rs, reads_rt;
    if (!m.valid || !m.ctrl[6] || m.rt == 0 || id_valid !== 1'b1) return 1'b0;
    reads_rs = !id_ctrl[2] && (m.rt == id_rs);
    reads_rt = (id_ctrl[10] || id_ctrl[5] || id_ctrl[4]) && (m.rt == id_rt);
    return reads_rs || reads_rt;
  endfunction

  task automatic cycle();
    bit hz, adv;
    slot_t empty;
    empty = '{default: 0};
    @(negedge clk);
    hz  = ref_hz();
    adv = rst || flush || !(ex_hold || hz);
    chk("pc_write", {127'b0, pc_write}, {127'b0, adv});
    chk("ifid_write", {127'b0, ifid_write}, {127'b0, adv});
    @(posedge clk);
    if (rst) begin
      m = empty;
      m_cnt = 0;
    end else if (flush) begin
      m = empty;
    end else if (!ex_hold) begin
      if (hz) begin
        m = empty;
        if (m_cnt < CNT_MAX) m_cnt++;
      end else begin
        m.valid = id_valid;
        m.ctrl  = id_valid ? id_ctrl : 11'b0;
        m.rs    = id_rs;
        m.rt    = id_rt;
        m.rd    = id_rd;
        m.d1    = id_rdata1;
        m.d2    = id_rdata2;
        m.imm   = id_imm;
        m.pc4   = id_pc4;
      end
    end
    #1;
    chk("ex_valid", {127'b0, ex_valid}, {127'b0, m.valid});
    chk("ex_ctrl", {117'b0, ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                    ex_memwrite, ex_branch, ex_extd, ex_jump, ex_aluop}, {117'b0, m.ctrl});
    chk("ex_regs", {113'b0, ex_rs, ex_rt, ex_rd}, {113'b0, m.rs, m.rt, m.rd});
    chk("ex_data", {ex_rdata1, ex_rdata2, ex_imm, ex_pc4}, {m.d1, m.d2, m.imm, m.pc4});
    chk("stall_count", {126'b0, stall_count}, 128'(m_cnt));
  endtask

  task automatic instr(input bit v, input bit [10:0] c, input bit [4:0] rs, input bit [4:0] rt,
                       input bit [4:0] rd, input bit [31:0] imm);
    id_valid  = v;
    id_ctrl   = c;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
    id_imm    = imm;
    id_rdata1 = $urandom;
    id_rdata2 = $urandom;
    id_pc4    = {$urandom_range(0, 32'hffff), 2'b00};
  endtask

  initial begin
    m = '{default: 0};
    m_cnt = 0;
    rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
    instr(1, C_ADDI, 1, 2, 3, 32'h4);

    // Reset with a live regwrite instruction in ID.
    cycle(); cycle();
    chk("rst_ex_valid", {127'b0, ex_valid}, 128'd0);
    chk("rst_regwrite", {127'b0, ex_regwrite}, 128'd0);
    rst = 1'b0;

    // Pass-through of addi.
    instr(1, C_ADDI, 5, 6, 0, 32'h10);
    cycle();
    chk("addi_imm", {96'b0, ex_imm}, 128'h10);
    chk("addi_rt", {123'b0, ex_rt}, 128'd6);

    // Load-use: exactly one bubble, then the R-type enters EX.
    instr(1, C_LW, 1, 8, 0, 32'h0);
    cycle();
    instr(1, C_RTYPE, 8, 9, 10, 32'h0);
    cycle();
    chk("lu_bubble", {127'b0, ex_valid}, 128'd0);
    chk("lu_count", {126'b0, stall_count}, 128'd1);
    cycle();
    chk("lu_enter_rs", {123'b0, ex_rs}, 128'd8);

    // No false hazards: load to $0, and a non-source rt.
    instr(1, C_LW, 1, 0, 0, 32'h0);    cycle();
    instr(1, C_RTYPE, 0, 2, 3, 32'h0); cycle();
    instr(1, C_LW, 1, 8, 0, 32'h0);    cycle();
    instr(1, C_ADDI, 3, 8, 0, 32'h1);  cycle();
    chk("addi_no_stall", {127'b0, ex_valid}, 128'd1);

    // Jump whose rs field collides with the load target.
    instr(1, C_LW, 1, 8, 0, 32'h0);    cycle();
    instr(1, C_J, 8, 0, 0, 32'h40);    cycle();
    chk("jump_pass", {126'b0, ex_jump, ex_regwrite}, 128'd2);

    // Flush coinciding with a hazard: flush bubble, no count.
    instr(1, C_LW, 1, 8, 0, 32'h0);    cycle();
    instr(1, C_BEQ, 8, 4, 0, 32'h8);
    flush = 1'b1; cycle(); flush = 1'b0;
    chk("flush_count", {126'b0, stall_count}, 128'd1);

    // Hold for three cycles.
    instr(1, C_SW, 2, 7, 0, 32'h20); cycle();
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr(1, C_ADDI, 4, 5, 0, 32'h30 + 32'(i));
      cycle();
    end
    ex_hold = 1'b0;
    chk("hold_frozen", {96'b0, ex_imm}, 128'h20);

    // Drive the counter into saturation and past it.
    for (int i = 0; i < 4; i++) begin
      instr(1, C_LW, 1, 9, 0, 32'h0);      cycle();
      instr(1, C_SW, 3, 9, 0, 32'h4);      cycle(); cycle();
    end
    chk("saturated", {126'b0, stall_count}, 128'd3);

    // Reset arriving while a hazard is pending.
    instr(1, C_LW, 1, 8, 0, 32'h0);    cycle();
    instr(1, C_RTYPE, 8, 9, 1, 32'h0);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("rst_mid_valid", {127'b0, ex_valid}, 128'd0);
    cycle();
    chk("rst_mid_enter", {127'b0, ex_valid}, 128'd1);

    // Random traffic on a narrow register range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      bit [10:0] c;
      case ($urandom_range(0, 6))
        0: c = C_ADDI;
        1, 2: c = C_LW;
        3: c = C_RTYPE;
        4: c = C_BEQ;
        5: c = C_SW;
        default: c = 11'($urandom);
      endcase
      instr($urandom_range(0, 99) < 85, c, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom);
      rst     = $urandom_range(0, 99) < 2;
      flush   = $urandom_range(0, 99) < 10;
      ex_hold = $urandom_range(0, 99) < 15;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core, directly downstream of the main control decoder.
- Latches the decoder's control bundle together with register operands, immediate, PC+4 and register specifiers into the EX stage.
- Contains load-use hazard detection: inserts a bubble into EX and stalls PC and IF/ID for one cycle.
- Handles branch/jump flush and downstream hold, and keeps a saturating stall-event counter.

Parameters:
- DATA_W, 32, width of operands, immediate and PC+4.
- REG_ADDR_W, 5, register specifier width.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction. When 0, decoder outputs are ignored and treated as all-zero.
- id_regdst, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_extd, id_jump  in  1 each  decoder control bits.
- id_aluop  in  2  decoder ALUOp.
- id_rs, id_rt, id_rd  in  REG_ADDR_W  instruction register fields.
- id_rdata1, id_rdata2, id_imm, id_pc4  in  DATA_W  operands, extended immediate, PC+4.
- flush  in  1  branch/jump taken (resolved downstream); kill the ID instruction.
- ex_hold  in  1  downstream multi-cycle hold; freeze ID/EX.
- ex_* (same nine control bits, plus ex_aluop, ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_pc4)  out  matching widths  registered copies.
- ex_valid  out  1  EX slot holds a real instruction.
- pc_write  out  1  combinational; 0 stalls the PC.
- ifid_write  out  1  combinational; 0 stalls IF/ID.
- stall_count  out  CNT_W  number of load-use bubbles inserted; saturates at all-ones.

Behaviour:
- Reset: rst=1 at a clock edge clears every ex_* output, ex_valid and stall_count to 0. pc_write and ifid_write are 1 while rst=1.
- Source-use decode (combinational):
  - uses_rs = id_valid & ~id_jump.
  - uses_rt = id_valid & (id_regdst | id_memwrite | id_branch).
- Load-use hazard (combinational):
  - hz = ex_valid & ex_memread & (ex_rt != 0) & ((uses_rs & ex_rt==id_rs) | (uses_rt & ex_rt==id_rt)).
- Per-edge priority, highest first:
  1. rst: as above.
  2. flush: load a bubble (all ex_* control bits 0, ex_aluop 0, ex_valid 0). Data/specifier fields are don't-care and are loaded with 0. stall_count is unchanged.
  3. ex_hold: all ex_* registers keep their value. pc_write=0 and ifid_write=0. The hazard is not counted.
  4. hz: load a bubble as in (2). pc_write=0 and ifid_write=0. stall_count increments unless already all-ones.
  5. Normal: latch all id_* fields.
     - ex_valid = id_valid.
     - When id_valid=0, all control bits load as 0; data fields are still latched.
- pc_write = ifid_write = ~(ex_hold | hz) when flush=0. They are 1 when flush=1, so the fetch redirect proceeds.
- Latency: exactly one cycle from ID to EX. Back-to-back instructions produce no bubble when hz=0.
- A load followed by a dependent instruction yields exactly one bubble. On the next cycle ex_memread=0, so hz clears and the dependent instruction latches.
- ex_rt==0 never raises hz (register $0).
- A jump in ID does not raise hz via rs. Jumps carry jump=1 and regwrite=0 into EX unchanged.
- Flush coinciding with hz: the flush bubble wins, stall_count does not increment, and pc_write=1.
- Reset asserted mid-stall: the cycle after reset has ex_valid=0 and no hazard.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants (OP_RTYPE 6'h00, OP_J 6'h02, OP_BEQ 6'h04, OP_ADDI 6'h08, OP_LW 6'h23, OP_SW 6'h2b).
  - ALUOp encodings (2'b00 add, 2'b01 sub, 2'b10 funct, 2'b11 immediate).
  - A packed control-bundle typedef (11 bits, same field order as the decoder output) so ID/EX and later pipeline registers use one type.
- One natural sub-module: load_use_detect, the purely combinational hz/uses_rs/uses_rt logic, reused later by the EX/MEM forwarding work.

Test Plan:
- Reset: drive rst=1 for 2 cycles with id_valid=1 and id_regwrite=1 -> all ex_* =0, ex_valid=0, stall_count=0, pc_write=1.
- Pass-through: addi (alusrc=1, regwrite=1, aluop=2'b11), rs=5, rt=6, imm=32'h10 -> next cycle the ex_* values match, ex_valid=1, no stall.
- Load-use: lw with rt=8, then R-type with rs=8, rt=9 -> one cycle of pc_write=0 and ifid_write=0 with a bubble in EX; the R-type enters EX the following cycle; stall_count=1.
- No false hazard:
  - lw with rt=0, then R-type with rs=0 -> no stall.
  - lw with rt=8, then addi with rt=8 and rs=3 -> no stall (rt is not a source).
- Flush vs hazard: lw rt=8, then beq rs=8 with flush=1 in the same cycle -> bubble, pc_write=1, stall_count unchanged.
- Hold and saturation:
  - ex_hold=1 for 3 cycles -> ex_* frozen and pc_write=0.
  - Preload stall_count to all-ones by 2^CNT_W hazards, or with CNT_W=2 via parameter, plus one more hazard -> stall_count stays 2'b11.
